fir_scie_sequencer: RTL

Upstream issue stage for the pipelined SCIE FIR accelerator. It takes coefficient writes and input samples over valid/ready streams and turns them into correctly spaced SCIE instruction slots: coefficient load, sample push, then result read. It captures each FIR result from `io_scie_rd` into a small output FIFO drained over valid/ready. It replaces hand-sequenced instruction issue, so the accelerator timing contract lives in one place.

---
 rtl/fir_scie_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fir_scie_sequencer.sv
// fir_scie_sequencer
//
// Issue stage in front of the pipelined SCIE FIR accelerator. Coefficient
// writes and input samples arrive on valid/ready streams. Each one becomes
// a correctly spaced sequence of SCIE instruction slots:
//   config : CFG (coef load)
//   sample : PUSH, mandatory bubble, READ, capture
// Each FIR result is captured from io_scie_rd into a small FIFO, which is
// drained on a valid/ready stream.
//
// Ports
//   clock, reset_n             : clock; asynchronous active-low reset
//   io_cfg_valid/ready/idx/coef: coefficient write stream
//   io_in_valid/ready/data     : sample stream
//   io_out_valid/ready/data    : result stream (FIFO head)
//   io_busy                    : sequencer is not idle
//   io_scie_valid/insn/rs1/rs2 : registered SCIE instruction slot
//   io_scie_rd                 : accelerator result, sampled in CAPT
module fir_scie_sequencer #(
    parameter int TAPS      = 5,
    parameter int OUT_DEPTH = 4,
    localparam int IDXW     = ($clog2(TAPS) > 1) ? $clog2(TAPS) : 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            io_cfg_valid,
    output logic            io_cfg_ready,
    input  logic [IDXW-1:0] io_cfg_idx,
    input  logic [31:0]     io_cfg_coef,
    input  logic            io_in_valid,
    output logic            io_in_ready,
    input  logic [31:0]     io_in_data,
    output logic            io_out_valid,
    input  logic            io_out_ready,
    output logic [31:0]     io_out_data,
    output logic            io_busy,
    output logic            io_scie_valid,
    output logic [31:0]     io_scie_insn,
    output logic [31:0]     io_scie_rs1,
    output logic [31:0]     io_scie_rs2,
    input  logic [31:0]     io_scie_rd
);

    localparam logic [31:0] INSN_CFG  = 32'h0000_000B;
    localparam logic [31:0] INSN_PUSH = 32'h0000_002B;
    localparam logic [31:0] INSN_READ = 32'h0000_005B;

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        PUSH,
        GAP,
        READ,
        CAPT
    } state_t;

    state_t          state;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     fifo_mem [OUT_DEPTH];

    logic            idle;
    logic            cfg_fire;
    logic            in_fire;
    logic            capt_write;
    logic            pop;

    assign idle = (state == IDLE);

    // Config wins over samples. A sample is only taken when a FIFO slot is
    // free, and nothing else can be in flight while idle, so each accepted
    // sample already owns the slot its result will land in.
    assign io_in_ready = idle && !io_cfg_valid && (count < CW'(OUT_DEPTH));
    assign cfg_fire    = idle && io_cfg_valid;
    assign in_fire     = io_in_valid && io_in_ready;

    assign capt_write   = (state == CAPT);
    assign io_out_valid = (count != '0);
    assign pop          = io_out_valid && io_out_ready;
    // Head is gated so the result bus reads 0 while the FIFO is empty.
    assign io_out_data  = io_out_valid ? fifo_mem[rd_ptr] : '0;

    // Sequencer. The slot outputs are loaded together with the state they
    // belong to, so the SCIE bus is purely registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            io_cfg_ready  <= 1'b1;
            io_busy       <= 1'b0;
            io_scie_valid <= 1'b0;
            io_scie_insn  <= '0;
            io_scie_rs1   <= '0;
            io_scie_rs2   <= '0;
        end else begin
            // Default slot is empty; only the issuing transitions fill it.
            io_scie_valid <= 1'b0;
            io_scie_insn  <= '0;
            io_scie_rs1   <= '0;
            io_scie_rs2   <= '0;
            case (state)
                IDLE: begin
                    if (cfg_fire) begin
                        state         <= CFG;
                        io_cfg_ready  <= 1'b0;
                        io_busy       <= 1'b1;
                        io_scie_valid <= 1'b1;
                        io_scie_insn  <= INSN_CFG;
                        io_scie_rs1   <= io_cfg_coef;
                        io_scie_rs2   <= {{(32 - IDXW){1'b0}}, io_cfg_idx};
                    end else if (in_fire) begin
                        state         <= PUSH;
                        io_cfg_ready  <= 1'b0;
                        io_busy       <= 1'b1;
                        io_scie_valid <= 1'b1;
                        io_scie_insn  <= INSN_PUSH;
                        io_scie_rs1   <= io_in_data;
                    end
                end
                CFG: begin
                    state        <= IDLE;
                    io_cfg_ready <= 1'b1;
                    io_busy      <= 1'b0;
                end
                PUSH: begin
                    // Accelerator needs one empty slot between PUSH and READ.
                    state <= GAP;
                end
                GAP: begin
                    state         <= READ;
                    io_scie_valid <= 1'b1;
                    io_scie_insn  <= INSN_READ;
                end
                READ: begin
                    // Result appears on io_scie_rd during the following cycle.
                    state <= CAPT;
                end
                CAPT: begin
                    state        <= IDLE;
                    io_cfg_ready <= 1'b1;
                    io_busy      <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    io_cfg_ready <= 1'b1;
                    io_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Result storage; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (capt_write) begin
            fifo_mem[wr_ptr] <= io_scie_rd;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (capt_write) begin
                wr_ptr <= (wr_ptr == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (capt_write && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !capt_write) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule
